// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register: one outstanding word read,
// tolerant of wait states, mid-fetch redirects (branch/flush) and stalls.
module fetch_unit #(
  parameter logic [29:0] RESET_VECTOR = 30'h0,
  parameter logic [31:0] NOP_INSN     = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] new_pc,
  input  logic        br_taken,
  input  logic [29:0] br_addr,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_rd_data,
  input  logic        imem_ready,
  output logic [29:0] if_pc,
  output logic [31:0] if_insn,
  output logic        if_en
);

  typedef enum logic [1:0] {S_FETCH, S_DROP, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [29:0] fetch_pc_q, fetch_pc_d;
  logic        outst_q, outst_d;
  logic        redir_valid_q, redir_valid_d;
  logic [29:0] redir_pc_q, redir_pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_insn_q, hold_insn_d;
  logic [29:0] hold_pc_q, hold_pc_d;
  logic [29:0] if_pc_q, if_pc_d;
  logic [31:0] if_insn_q, if_insn_d;
  logic        if_en_q, if_en_d;

  logic        done;
  logic        pend;
  logic [29:0] seq_pc;

  always_comb begin
    imem_req = 1'b0;
    case (state_q)
      S_FETCH: imem_req = !stall || outst_q;
      S_DROP:  imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
    if (reset) imem_req = 1'b0;
  end

  assign imem_addr = fetch_pc_q;
  assign done      = imem_req && imem_ready;
  assign pend      = imem_req && !imem_ready;
  assign seq_pc    = redir_valid_q ? redir_pc_q : fetch_pc_q + 30'd1;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outst_d       = pend;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    hold_valid_d  = hold_valid_q;
    hold_insn_d   = hold_insn_q;
    hold_pc_d     = hold_pc_q;
    if_pc_d       = if_pc_q;
    if_insn_d     = if_insn_q;
    if_en_d       = if_en_q;

    if (done) begin
      fetch_pc_d    = seq_pc;
      redir_valid_d = 1'b0;
    end

    if (flush) begin
      if_insn_d    = NOP_INSN;
      if_en_d      = 1'b0;
      hold_valid_d = 1'b0;
      // A request in flight cannot be withdrawn: let it finish in DROP and
      // park the flush target as a pending redirect.
      if (pend) begin
        state_d       = S_DROP;
        redir_pc_d    = new_pc;
        redir_valid_d = 1'b1;
      end else begin
        fetch_pc_d    = new_pc;
        redir_valid_d = 1'b0;
        state_d       = S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (stall) begin
            if (done) begin
              hold_valid_d = 1'b1;
              hold_insn_d  = imem_rd_data;
              hold_pc_d    = fetch_pc_q;
              state_d      = S_HOLD;
            end
          end else if (done) begin
            if_pc_d   = fetch_pc_q;
            if_insn_d = imem_rd_data;
            if_en_d   = 1'b1;
          end else begin
            if_insn_d = NOP_INSN;
            if_en_d   = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            if_pc_d      = hold_pc_q;
            if_insn_d    = hold_insn_q;
            if_en_d      = hold_valid_q;
            hold_valid_d = 1'b0;
            state_d      = S_FETCH;
          end
        end
        default: begin
          if_insn_d = NOP_INSN;
          if_en_d   = 1'b0;
          if (done) state_d = S_FETCH;
        end
      endcase

      // Delay slot: whatever is being fetched or held is delivered first.
      if (!stall && br_taken) begin
        if (pend) begin
          redir_valid_d = 1'b1;
          redir_pc_d    = br_addr;
        end else begin
          fetch_pc_d = br_addr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      fetch_pc_q    <= RESET_VECTOR;
      outst_q       <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      hold_valid_q  <= 1'b0;
      hold_insn_q   <= NOP_INSN;
      hold_pc_q     <= '0;
      if_pc_q       <= '0;
      if_insn_q     <= NOP_INSN;
      if_en_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outst_q       <= outst_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      hold_valid_q  <= hold_valid_d;
      hold_insn_q   <= hold_insn_d;
      hold_pc_q     <= hold_pc_d;
      if_pc_q       <= if_pc_d;
      if_insn_q     <= if_insn_d;
      if_en_q       <= if_en_d;
    end
  end

  assign if_pc   = if_pc_q;
  assign if_insn = if_insn_q;
  assign if_en   = if_en_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, checked by a
// program-order scoreboard and a memory-protocol monitor.
module tb_fetch_unit;

  localparam logic [29:0] RV  = 30'h100;
  localparam logic [31:0] NOP = 32'h0;

  logic        clk = 1'b0;
  logic        reset, stall, flush, br_taken, imem_ready;
  logic [29:0] new_pc, br_addr;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic [31:0] imem_rd_data;
  logic [29:0] if_pc;
  logic [31:0] if_insn;
  logic        if_en;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned deliveries = 0;

  logic [29:0] exp_q[$];
  logic [29:0] tail_pc;

  fetch_unit #(.RESET_VECTOR(RV), .NOP_INSN(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_taken(br_taken), .br_addr(br_addr), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rd_data(imem_rd_data), .imem_ready(imem_ready),
    .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a[13:0], 2'b01, a[29:14]} ^ 32'hA5C3_0F96;
  endfunction

  assign imem_rd_data = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program-order model: the stream of instruction addresses still to be
  // delivered; a taken branch keeps exactly one (the delay slot).
  task automatic m_reset();
    exp_q.delete();
    tail_pc = RV;
  endtask

  task automatic m_flush(input logic [29:0] t);
    exp_q.delete();
    tail_pc = t;
  endtask

  task automatic m_branch(input logic [29:0] t);
    if (exp_q.size() == 0) begin
      exp_q.push_back(tail_pc);
      tail_pc = tail_pc + 30'd1;
    end
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    tail_pc = t;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard monitor: IF/ID takes new contents on any edge without
  // reset/stall/flush; a valid entry there is the next program-order item.
  initial begin
    logic [29:0] p;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (!stall && !flush && if_en) begin
          if (exp_q.size() == 0) begin
            exp_q.push_back(tail_pc);
            tail_pc = tail_pc + 30'd1;
          end
          p = exp_q.pop_front();
          check("deliver_pc", 32'(if_pc), 32'(p));
          check("deliver_insn", if_insn, mem_word(p));
          deliveries++;
        end else if (!if_en) begin
          check("bubble_insn", if_insn, NOP);
        end
      end
    end
  end

  // Memory protocol: an unfinished request stays up with the same address.
  initial begin
    logic        pend_prev = 1'b0;
    logic [29:0] addr_prev = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!reset && pend_prev) begin
        check("req_held", 32'(imem_req), 32'd1);
        check("addr_stable", 32'(imem_addr), 32'(addr_prev));
      end
      pend_prev = !reset && imem_req && !imem_ready;
      addr_prev = imem_addr;
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    imem_ready = 1'b1; new_pc = '0; br_addr = '0;
    m_reset();
    step();
    step();
    check("reset_if_en", 32'(if_en), 32'd0);
    check("reset_if_pc", 32'(if_pc), 32'd0);
    check("reset_if_insn", if_insn, NOP);
    check("reset_req", 32'(imem_req), 32'd0);
    check("reset_addr", 32'(imem_addr), 32'(RV));

    reset = 1'b0; m_reset();
    step();
    check("first_if_en", 32'(if_en), 32'd1);
    check("first_if_pc", 32'(if_pc), 32'(RV));
    step();

    // Three wait states on 0x102
    for (int i = 0; i < 3; i++) begin
      check("wait_addr", 32'(imem_addr), 32'h102);
      imem_ready = 1'b0;
      step();
      check("wait_bubble", 32'(if_en), 32'd0);
    end
    check("wait_addr", 32'(imem_addr), 32'h102);
    imem_ready = 1'b1;
    step();
    check("wait_done_pc", 32'(if_pc), 32'h102);

    // Branch with delay slot, zero-wait
    br_taken = 1'b1; br_addr = 30'h200; m_branch(30'h200);
    step();
    br_taken = 1'b0;
    check("br_slot_pc", 32'(if_pc), 32'h103);
    step();
    check("br_target_pc", 32'(if_pc), 32'h200);

    // Branch while the delay-slot fetch waits
    br_taken = 1'b1; br_addr = 30'h300; imem_ready = 1'b0; m_branch(30'h300);
    step();
    br_taken = 1'b0;
    check("redir_bubble", 32'(if_en), 32'd0);
    step();
    imem_ready = 1'b1;
    step();
    check("redir_slot_pc", 32'(if_pc), 32'h201);
    step();
    check("redir_target_pc", 32'(if_pc), 32'h300);

    // Stall while a fetch is outstanding and completes
    imem_ready = 1'b0;
    step();
    stall = 1'b1; imem_ready = 1'b1;
    step();
    check("hold_if_en", 32'(if_en), 32'd0);
    check("hold_req", 32'(imem_req), 32'd0);
    step();
    check("hold_req2", 32'(imem_req), 32'd0);
    stall = 1'b0;
    #1;
    check("release_req", 32'(imem_req), 32'd0);
    step();
    check("release_pc", 32'(if_pc), 32'h301);
    check("release_en", 32'(if_en), 32'd1);
    check("after_release_req", 32'(imem_req), 32'd1);
    step();
    check("after_release_pc", 32'(if_pc), 32'h302);

    // Flush during a pending fetch, with a branch that must be ignored
    imem_ready = 1'b0;
    step();
    step();
    flush = 1'b1; new_pc = 30'h3F0; br_taken = 1'b1; br_addr = 30'h155;
    m_flush(30'h3F0);
    step();
    flush = 1'b0; br_taken = 1'b0;
    check("flush_if_en", 32'(if_en), 32'd0);
    imem_ready = 1'b1;
    #1;
    check("drop_req", 32'(imem_req), 32'd1);
    check("drop_addr", 32'(imem_addr), 32'h303);
    step();
    check("drop_discard_en", 32'(if_en), 32'd0);
    check("flush_target_addr", 32'(imem_addr), 32'h3F0);
    check("flush_target_req", 32'(imem_req), 32'd1);
    step();
    check("flush_target_pc", 32'(if_pc), 32'h3F0);

    // Address wrap, then reset while waiting
    flush = 1'b1; new_pc = 30'h3FFF_FFFE; m_flush(30'h3FFF_FFFE);
    step();
    flush = 1'b0;
    step();
    check("wrap_pc0", 32'(if_pc), 32'h3FFF_FFFE);
    step();
    check("wrap_pc1", 32'(if_pc), 32'h3FFF_FFFF);
    step();
    check("wrap_pc2", 32'(if_pc), 32'h0);
    imem_ready = 1'b0;
    step();
    reset = 1'b1;
    m_reset();
    #1;
    check("midwait_reset_req", 32'(imem_req), 32'd0);
    step();
    check("midwait_reset_en", 32'(if_en), 32'd0);
    check("midwait_reset_pc", 32'(if_pc), 32'd0);
    check("midwait_reset_insn", if_insn, NOP);
    check("midwait_reset_addr", 32'(imem_addr), 32'(RV));

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 499) == 0);
      flush      = !reset && ($urandom_range(0, 39) == 0);
      stall      = ($urandom_range(0, 6) == 0);
      imem_ready = ($urandom_range(0, 9) < 7);
      new_pc     = 30'($urandom);
      br_addr    = 30'($urandom);
      br_taken   = !reset && !flush && !stall && if_en && ($urandom_range(0, 4) == 0);
      if (reset)         m_reset();
      else if (flush)    m_flush(new_pc);
      else if (br_taken) m_branch(br_addr);
      step();
    end
    reset = 1'b0; flush = 1'b0; stall = 1'b0; br_taken = 1'b0;
    step();
    check("delivery_count_min", 32'(deliveries >= 300), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
